// File: rtl/memctrl_arb_pkg.sv
// memctrl_arb_pkg: shared types and constants for the MEMCTRL round-robin arbiter.
// The optional grant statistics are enabled with the MEMCTRL_ARB_STATS_EN macro.
package memctrl_arb_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      WAIT    = 2'd2,
      RECOVER = 2'd3
   } state_e;

   // MEMCTRL strobe bundle, kept together so idle/active values are one assignment.
   typedef struct packed {
      logic ce;
      logic csb;
      logic web;
      logic oeb;
   } strobe_t;

   localparam strobe_t STROBE_IDLE = '{ce: 1'b0, csb: 1'b1, web: 1'b1, oeb: 1'b1};

   // Strobe values for the single access cycle of a read (we=0) or write (we=1).
   function automatic strobe_t strobe_access(input logic we);
      strobe_t s;
      s.ce  = 1'b1;
      s.csb = 1'b0;
      s.web = ~we;
      s.oeb = we;
      return s;
   endfunction

endpackage

// File: rtl/memctrl_arb_rr.sv
// memctrl_arb_rr: combinational round-robin picker plus the "last winner" pointer.
// Search order starts just after the last winner, so requester 0 wins first after reset.
module memctrl_arb_rr #(
   parameter int NREQ  = 2,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [NREQ-1:0]  i_req,
   input  logic             i_load,
   output logic [IDX_W-1:0] o_winner,
   output logic             o_valid
);

   logic [IDX_W-1:0] r_last;
   int               w_idx;

   // Pointer update: remember the requester just granted.
   always_ff @(posedge i_clk or posedge i_rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (i_rst) begin
         r_last <= IDX_W'(NREQ - 1);
      end else if (i_load) begin
         r_last <= o_winner;
      end
   end

   // Winner search: scan farthest-first so the nearest candidate after r_last overwrites the rest.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      o_valid  = 1'b0;
      o_winner = '0;
      w_idx    = 0;
      for (int k = NREQ; k >= 1; k--) begin
         w_idx = (int'(r_last) + k) % NREQ;
         if (i_req[w_idx]) begin
            o_valid  = 1'b1;
            o_winner = IDX_W'(w_idx);
         end
      end
   end

endmodule

// File: rtl/memctrl_arb.sv
// memctrl_arb: round-robin sequencer sharing one MEMCTRL SRAM port among NREQ requesters.
// One access per strobe cycle followed by an idle/arbitration cycle; reads add RD_LAT wait cycles.
// Define MEMCTRL_ARB_STATS_EN to add the per-requester saturating grant counters (GNT_CNT).
module memctrl_arb
   import memctrl_arb_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int RD_LAT = 1,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [NREQ-1:0]          REQ,
   input  logic [NREQ-1:0]          REQ_WE,
   input  logic [NREQ*ADDR_W-1:0]   REQ_ADDR,
   input  logic [NREQ*DATA_W-1:0]   REQ_WDATA,
   output logic [NREQ-1:0]          GNT,
   output logic [NREQ-1:0]          RVALID,
   output logic [DATA_W-1:0]        RDATA,
   output logic                     BUSY,
   output logic                     CE,
   output logic                     CSB,
   output logic                     WEB,
   output logic                     OEB,
   output logic [ADDR_W-1:0]        ADDR,
   output logic [DATA_W-1:0]        IDATA,
`ifdef MEMCTRL_ARB_STATS_EN
   output logic [NREQ*16-1:0]       GNT_CNT,
`endif
   input  logic [DATA_W-1:0]        ODATA
);

   localparam int IDX_W = $clog2(NREQ);
   localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   // Control state
   state_e           r_state;
   logic             r_we;
   logic [IDX_W-1:0] r_win;
   logic [CNT_W-1:0] r_wait_cnt;

   // Registered outputs
   strobe_t          r_strobe;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_idata;
   logic [NREQ-1:0]  r_gnt;
   logic [NREQ-1:0]  r_rvalid;
   logic [DATA_W-1:0] r_rdata;
   logic             r_busy;

   // Next-state / next-output wires
   state_e           w_next;
   logic             w_load;
   logic [CNT_W-1:0] w_wait_cnt;
   strobe_t          w_strobe;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_idata;
   logic [NREQ-1:0]  w_gnt;
   logic [NREQ-1:0]  w_rvalid;
   logic [DATA_W-1:0] w_rdata;

   // Arbitration result and the winner's request fields
   logic [IDX_W-1:0] w_winner;
   logic             w_valid;
   logic             w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic [NREQ-1:0]  w_winner_oh;
   logic [NREQ-1:0]  w_latched_oh;

   memctrl_arb_rr #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .i_clk    (CLK),
      .i_rst    (RST),
      .i_req    (REQ),
      .i_load   (w_load),
      .o_winner (w_winner),
      .o_valid  (w_valid)
   );

   // Mux out the winning requester's fields and build one-hot vectors for grant/read-valid.
   always_comb begin
      w_sel_we     = 1'b0;
      w_sel_addr   = '0;
      w_sel_wdata  = '0;
      w_winner_oh  = '0;
      w_latched_oh = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_winner == IDX_W'(i)) begin
            w_sel_we       = REQ_WE[i];
            w_sel_addr     = REQ_ADDR[i*ADDR_W +: ADDR_W];
            w_sel_wdata    = REQ_WDATA[i*DATA_W +: DATA_W];
            w_winner_oh[i] = 1'b1;
         end
         if (r_win == IDX_W'(i)) begin
            w_latched_oh[i] = 1'b1;
         end
      end
   end

   // Next state and next registered outputs; the idle/recover slot doubles as arbitration.
   always_comb begin
      w_next     = r_state;
      w_load     = 1'b0;
      w_wait_cnt = r_wait_cnt;
      w_strobe   = STROBE_IDLE;
      w_addr     = r_addr;
      w_idata    = '0;
      w_gnt      = '0;
      w_rvalid   = '0;
      w_rdata    = r_rdata;
      unique case (r_state)
         IDLE, RECOVER: begin
            if (w_valid) begin
               w_next   = ACCESS;
               w_load   = 1'b1;
               w_strobe = strobe_access(w_sel_we);
               w_addr   = w_sel_addr;
               w_idata  = w_sel_we ? w_sel_wdata : '0;
               w_gnt    = w_winner_oh;
            end else begin
               w_next = IDLE;
            end
         end
         ACCESS: begin
            if (r_we) begin
               w_next = RECOVER;
            end else begin
               w_next     = WAIT;
               w_wait_cnt = CNT_W'(RD_LAT - 1);
            end
         end
         WAIT: begin
            if (r_wait_cnt == '0) begin
               w_next   = RECOVER;
               w_rdata  = ODATA;
               w_rvalid = w_latched_oh;
            end else begin
               w_wait_cnt = r_wait_cnt - CNT_W'(1);
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // State register plus the access context captured at the edge entering ACCESS.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= IDLE;
         r_we       <= 1'b0;
         r_win      <= '0;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_next;
         r_wait_cnt <= w_wait_cnt;
         if (w_load) begin
            r_we  <= w_sel_we;
            r_win <= w_winner;
         end
      end
   end

   // Output registers: every port is driven straight from a flop.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_strobe <= STROBE_IDLE;
         r_addr   <= '0;
         r_idata  <= '0;
         r_gnt    <= '0;
         r_rvalid <= '0;
         r_rdata  <= '0;
         r_busy   <= 1'b0;
      end else begin
         r_strobe <= w_strobe;
         r_addr   <= w_addr;
         r_idata  <= w_idata;
         r_gnt    <= w_gnt;
         r_rvalid <= w_rvalid;
         r_rdata  <= w_rdata;
         r_busy   <= (w_next != IDLE);
      end
   end

   assign CE     = r_strobe.ce;
   assign CSB    = r_strobe.csb;
   assign WEB    = r_strobe.web;
   assign OEB    = r_strobe.oeb;
   assign ADDR   = r_addr;
   assign IDATA  = r_idata;
   assign GNT    = r_gnt;
   assign RVALID = r_rvalid;
   assign RDATA  = r_rdata;
   assign BUSY   = r_busy;

`ifdef MEMCTRL_ARB_STATS_EN
   logic [NREQ*16-1:0] r_gnt_cnt;

   // Grant statistics: one saturating counter per requester, bumped on each GNT pulse.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_gnt_cnt <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (r_gnt[i] && (r_gnt_cnt[i*16 +: 16] != 16'hFFFF)) begin
               r_gnt_cnt[i*16 +: 16] <= r_gnt_cnt[i*16 +: 16] + 16'd1;
            end
         end
      end
   end

   assign GNT_CNT = r_gnt_cnt;
`endif

endmodule

// File: tb/tb_memctrl_arb.sv
// tb_memctrl_arb: self-checking bench for memctrl_arb.
// A transaction-level schedule model predicts every output each cycle; directed phases
// pin the model with literal expectations, then a randomized phase exercises fairness.
module tb_memctrl_arb;

   localparam int NREQ   = 2;
   localparam int RD_LAT = 1;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   logic                   CLK;
   logic                   RST;
   logic [NREQ-1:0]        REQ;
   logic [NREQ-1:0]        REQ_WE;
   logic [NREQ*ADDR_W-1:0] REQ_ADDR;
   logic [NREQ*DATA_W-1:0] REQ_WDATA;
   logic [NREQ-1:0]        GNT;
   logic [NREQ-1:0]        RVALID;
   logic [DATA_W-1:0]      RDATA;
   logic                   BUSY;
   logic                   CE, CSB, WEB, OEB;
   logic [ADDR_W-1:0]      ADDR;
   logic [DATA_W-1:0]      IDATA;
   logic [DATA_W-1:0]      ODATA;
`ifdef MEMCTRL_ARB_STATS_EN
   logic [NREQ*16-1:0]     GNT_CNT;
`endif

   int n_checks = 0;
   int n_errors = 0;

   memctrl_arb #(
      .NREQ   (NREQ),
      .RD_LAT (RD_LAT),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .REQ       (REQ),
      .REQ_WE    (REQ_WE),
      .REQ_ADDR  (REQ_ADDR),
      .REQ_WDATA (REQ_WDATA),
      .GNT       (GNT),
      .RVALID    (RVALID),
      .RDATA     (RDATA),
      .BUSY      (BUSY),
      .CE        (CE),
      .CSB       (CSB),
      .WEB       (WEB),
      .OEB       (OEB),
      .ADDR      (ADDR),
      .IDATA     (IDATA),
`ifdef MEMCTRL_ARB_STATS_EN
      .GNT_CNT   (GNT_CNT),
`endif
      .ODATA     (ODATA)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- SRAM model: ODATA valid exactly RD_LAT cycles after a read strobe
   logic [DATA_W-1:0] sram [0:65535];
   int                sram_lat;

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         sram_lat <= 0;
      end else begin
         if (CE && !CSB && !WEB) sram[ADDR] <= IDATA;
         if (CE && !CSB && !OEB) sram_lat <= 1;
         else if (sram_lat != 0) sram_lat <= sram_lat + 1;
      end
   end

   assign ODATA = (sram_lat == RD_LAT) ? sram[ADDR] : ~sram[ADDR];

   // ---------------- Behavioural schedule model
   logic [DATA_W-1:0] shadow [0:65535];
   int                cyc = 0;
   int                ready_at = 0;     // first cycle whose closing edge may arbitrate
   int                busy_until = -1;  // last cycle of the current transaction
   int                rv_cycle = -1;
   int                rv_who = 0;
   logic [DATA_W-1:0] rv_data = '0;
   int                m_last = NREQ - 1;
   int                m_cnt [NREQ];

   logic [NREQ-1:0]   exp_gnt = '0;
   logic [NREQ-1:0]   exp_rvalid = '0;
   logic [DATA_W-1:0] exp_rdata = '0;
   logic              exp_busy = 1'b0;
   logic [3:0]        exp_strobe = 4'b0111;  // {CE,CSB,WEB,OEB}
   logic [ADDR_W-1:0] exp_addr = '0;
   logic [DATA_W-1:0] exp_idata = '0;

   initial begin
      for (int a = 0; a < 65536; a++) begin
         sram[a]   = DATA_W'(a) ^ 8'h3C;
         shadow[a] = DATA_W'(a) ^ 8'h3C;
      end
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
   end

   // Predict the outputs of the cycle that begins at this edge.
   always @(posedge CLK) begin
      int w;
      logic [ADDR_W-1:0] a;
      if (RST) begin
         ready_at   = 0;
         busy_until = -1;
         rv_cycle   = -1;
         m_last     = NREQ - 1;
         for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
         exp_gnt = '0; exp_rvalid = '0; exp_rdata = '0; exp_busy = 1'b0;
         exp_strobe = 4'b0111; exp_addr = '0; exp_idata = '0;
      end else begin
         exp_gnt    = '0;
         exp_rvalid = '0;
         exp_strobe = 4'b0111;
         exp_idata  = '0;
         if (cyc >= ready_at) begin
            w = -1;
            for (int k = NREQ; k >= 1; k--) begin
               if (REQ[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
            end
            if (w >= 0) begin
               m_last     = w;
               m_cnt[w]++;
               exp_gnt[w] = 1'b1;
               a          = REQ_ADDR[w*ADDR_W +: ADDR_W];
               exp_addr   = a;
               if (REQ_WE[w]) begin
                  exp_strobe = 4'b1001;
                  exp_idata  = REQ_WDATA[w*DATA_W +: DATA_W];
                  shadow[a]  = REQ_WDATA[w*DATA_W +: DATA_W];
                  ready_at   = cyc + 2;
               end else begin
                  exp_strobe = 4'b1010;
                  rv_data    = shadow[a];
                  rv_who     = w;
                  rv_cycle   = cyc + RD_LAT + 2;
                  ready_at   = cyc + RD_LAT + 2;
               end
               busy_until = ready_at;
            end
         end
         if (cyc + 1 == rv_cycle) begin
            exp_rvalid[rv_who] = 1'b1;
            exp_rdata          = rv_data;
         end
         exp_busy = (cyc + 1 <= busy_until);
      end
      cyc++;
   end

   // Compare every output against the model, away from the active edge.
   always @(negedge CLK) begin
      check("gnt",    64'(GNT),    64'(exp_gnt));
      check("rvalid", 64'(RVALID), 64'(exp_rvalid));
      check("rdata",  64'(RDATA),  64'(exp_rdata));
      check("busy",   64'(BUSY),   64'(exp_busy));
      check("strobe", 64'({CE, CSB, WEB, OEB}), 64'(exp_strobe));
      check("addr",   64'(ADDR),   64'(exp_addr));
      check("idata",  64'(IDATA),  64'(exp_idata));
   end

   // ---------------- Stimulus
   task automatic set_req(input int i, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
      REQ[i]                       = 1'b1;
      REQ_WE[i]                    = we;
      REQ_ADDR[i*ADDR_W +: ADDR_W] = a;
      REQ_WDATA[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic rand_fields(input int i);
      logic [ADDR_W-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
      set_req(i, 1'($urandom_range(0, 1)), a, DATA_W'($urandom));
   endtask

   initial begin
      RST = 1'b1; REQ = '0; REQ_WE = '0; REQ_ADDR = '0; REQ_WDATA = '0;

      // Reset held: outputs at reset values, no strobe activity.
      @(negedge CLK); @(negedge CLK);
      check("rst_busy",   64'(BUSY), 64'd0);
      check("rst_strobe", 64'({CE, CSB, WEB, OEB}), 64'h7);
      check("rst_gnt",    64'(GNT), 64'd0);
      @(negedge CLK); @(negedge CLK);   // t=40
      RST = 1'b0;

      // Single write from requester 0.
      @(negedge CLK); #1;
      set_req(0, 1'b1, 16'h0010, 8'hA5);
      @(negedge CLK);
      check("wr_strobe", 64'({CE, CSB, WEB, OEB}), 64'h9);
      check("wr_addr",   64'(ADDR),  64'h0010);
      check("wr_idata",  64'(IDATA), 64'hA5);
      check("wr_gnt",    64'(GNT),   64'b01);
      #1 REQ = '0;
      @(negedge CLK);
      check("wr_idle", 64'({CE, CSB, WEB, OEB}), 64'h7);

      // Read-after-write from requester 1.
      #1 set_req(1, 1'b0, 16'h0010, 8'h00);
      @(negedge CLK);
      check("rd_strobe", 64'({CE, CSB, WEB, OEB}), 64'hA);
      check("rd_gnt",    64'(GNT), 64'b10);
      #1 REQ = '0;
      @(negedge CLK);
      check("rd_wait_rvalid", 64'(RVALID), 64'd0);
      @(negedge CLK);
      check("rd_rvalid", 64'(RVALID), 64'b10);
      check("rd_rdata",  64'(RDATA),  64'hA5);

      // Contention: both requesters write continuously.
      #1;
      set_req(0, 1'b1, 16'h0020, 8'h11);
      set_req(1, 1'b1, 16'h0021, 8'h22);
      for (int k = 0; k < 8; k++) begin
         @(negedge CLK);
         check("cont_ce", 64'(CE), 64'((k % 2) == 0));
         if ((k % 2) == 0) check("cont_gnt", 64'(GNT), ((k / 2) % 2 == 0) ? 64'b01 : 64'b10);
         else              check("cont_gnt", 64'(GNT), 64'd0);
      end
      #1 REQ = '0;

      // Reset in the middle of a read by requester 0.
      @(negedge CLK); #1;
      set_req(0, 1'b0, 16'h0021, 8'h00);
      @(negedge CLK);
      check("mid_gnt", 64'(GNT), 64'b01);
      #1 REQ = '0;
      @(negedge CLK); #1;   // in WAIT
      RST = 1'b1;
      #1;
      check("mid_rst_strobe", 64'({CE, CSB, WEB, OEB}), 64'h7);
      check("mid_rst_rvalid", 64'(RVALID), 64'd0);
      check("mid_rst_busy",   64'(BUSY), 64'd0);
      @(negedge CLK);
      @(negedge CLK); #1;
      RST = 1'b0;
      set_req(0, 1'b1, 16'h0030, 8'h33);
      set_req(1, 1'b1, 16'h0031, 8'h44);
      @(negedge CLK);
      check("post_rst_gnt", 64'(GNT), 64'b01);
      #1 REQ = '0;
      @(negedge CLK); @(negedge CLK);

      // Randomized traffic with withdrawals and re-requests.
      for (int c = 0; c < 600; c++) begin
         @(negedge CLK); #1;
         for (int i = 0; i < NREQ; i++) begin
            if (REQ[i]) begin
               if (GNT[i]) begin
                  if ($urandom_range(0, 1) == 0) REQ[i] = 1'b0;
                  else rand_fields(i);
               end else if ($urandom_range(0, 15) == 0) begin
                  REQ[i] = 1'b0;
               end
            end else if ($urandom_range(0, 2) == 0) begin
               rand_fields(i);
            end
         end
      end
      REQ = '0;
      repeat (10) @(negedge CLK);

`ifdef MEMCTRL_ARB_STATS_EN
      for (int i = 0; i < NREQ; i++) begin
         check("gnt_cnt", 64'(GNT_CNT[i*16 +: 16]), 64'(m_cnt[i]));
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/memctrl_arb.md
Name: memctrl_arb

Overview:
- Round-robin arbiter/sequencer sharing one MEMCTRL SRAM-style port among NREQ requesters.
- Drives MEMCTRL strobes CE/CSB/WEB/OEB, ADDR and IDATA, samples ODATA, and returns read data to the granted requester.
- Issues one access per two cycles: a strobe cycle followed by an idle cycle, the idle cycle doubling as the arbitration slot.

Parameters:
- NREQ, 2, number of requesters (legal 2..4).
- RD_LAT, 1, cycles after the strobe cycle until ODATA is valid (legal 1..4).
- ADDR_W, 16, address width.
- DATA_W, 8, data width.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- REQ  in  NREQ  per-requester request level.
- REQ_WE  in  NREQ  1=write, 0=read.
- REQ_ADDR  in  NREQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- REQ_WDATA  in  NREQ*DATA_W  packed write data.
- GNT  out  NREQ  one-hot, one-cycle grant pulse.
- RVALID  out  NREQ  one-hot, one-cycle read-data-valid pulse.
- RDATA  out  DATA_W  read data; valid while RVALID is nonzero.
- BUSY  out  1  high in any state other than IDLE.
- CE  out  1  MEMCTRL chip enable.
- CSB  out  1  MEMCTRL chip select, active-low.
- WEB  out  1  MEMCTRL write enable, active-low.
- OEB  out  1  MEMCTRL output enable, active-low.
- ADDR  out  ADDR_W  MEMCTRL address.
- IDATA  out  DATA_W  MEMCTRL write data.
- ODATA  in  DATA_W  MEMCTRL read data.

Behaviour:
- Reset values (async on RST=1): state=IDLE, CE=0, CSB=1, WEB=1, OEB=1, ADDR=0, IDATA=0, GNT=0, RVALID=0, RDATA=0, BUSY=0, rr pointer LAST=NREQ-1 (requester 0 wins first).
- All outputs are registered.
- States: IDLE, ACCESS, WAIT, RECOVER.
- Arbitration is evaluated in IDLE and RECOVER only:
  - Winner is the first i with REQ[i]=1, searching LAST+1, LAST+2, ... mod NREQ.
  - If a winner exists: latch its WE/ADDR/WDATA, set LAST=winner, go to ACCESS.
  - Otherwise go to (or stay in) IDLE.
- ACCESS (exactly one cycle):
  - CE=1, CSB=0, ADDR=latched address, GNT[winner]=1.
  - Write: WEB=0, OEB=1, IDATA=latched wdata; next state RECOVER.
  - Read: WEB=1, OEB=0, IDATA=0; next state WAIT.
- WAIT (RD_LAT cycles):
  - Strobes idle (CE=0, CSB=1, WEB=1, OEB=1, IDATA=0); ADDR holds.
  - On the edge ending the last WAIT cycle: RDATA<=ODATA; next state RECOVER.
- RECOVER (one cycle):
  - Strobes idle; RVALID[winner]=1 if the completed access was a read; re-arbitrates.
  - Outside RVALID cycles RDATA holds its last value.
- Throughput: back-to-back writes complete one per 2 cycles; reads one per RD_LAT+2 cycles.
- Requester rules:
  - Hold REQ, REQ_WE, REQ_ADDR and REQ_WDATA stable from REQ rise until GNT is seen.
  - Inputs are captured at the edge entering ACCESS; later changes are ignored.
  - Dropping REQ before grant withdraws the request with no side effect.
  - A requester keeping REQ high after GNT is treated as a new request and competes fairly at the next arbitration.
- Simultaneous requests: served in strict rotation; with all NREQ requesting, each is granted once per NREQ accesses.
- Reset mid-operation: access is abandoned immediately, strobes return to idle values asynchronously, no GNT/RVALID is produced, LAST returns to NREQ-1.
- Out-of-range ADDR values are not possible; full ADDR_W is passed through unmodified.

Optional Feature:
- Macro MEMCTRL_ARB_STATS_EN.
- When defined: adds output GNT_CNT (NREQ*16 bits), one saturating 16-bit counter per requester, incremented on each GNT pulse, holding at 16'hFFFF, cleared by RST.
- When undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package memctrl_arb_pkg holds:
  - state enum typedef (IDLE, ACCESS, WAIT, RECOVER);
  - ADDR_W/DATA_W defaults;
  - localparam record of idle strobe values (CE=0, CSB=1, WEB=1, OEB=1).
- Sub-module memctrl_arb_rr: combinational round-robin picker (REQ, LAST -> winner index, valid), plus LAST register update.

Test Plan:
- Reset: RST=1 at t=0, released at 40ns -> all outputs at reset values throughout reset; BUSY=0; no strobe activity.
- Single write: REQ[0]=1, WE=1, ADDR=16'h0010, WDATA=8'hA5 -> next cycle CE=1, CSB=0, WEB=0, OEB=1, ADDR=16'h0010, IDATA=8'hA5, GNT=2'b01; following cycle strobes idle.
- Read after write: REQ[1] reads 16'h0010 -> OEB=0 strobe cycle, GNT=2'b10; after RD_LAT=1 WAIT cycle, RVALID=2'b10 with RDATA=8'hA5.
- Contention: REQ=2'b11 held continuously, all writes -> GNT sequence 01,10,01,10, each GNT 2 cycles apart, CE duty 50%.
- Reset mid-read: assert RST during WAIT -> CE=0, CSB=1, OEB=1 immediately; no RVALID; next request from requester 0 granted first.
- Stats (MEMCTRL_ARB_STATS_EN): 5 grants to requester 0, 3 to requester 1 -> GNT_CNT = {16'd3, 16'd5}.
